// File: rtl/al422_pkg.sv
// Shared definitions for the AL422 frame writer and its read-side counterpart.
package al422_pkg;

  // Write-controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRST   = 2'd1,
    ST_STREAM = 2'd2
  } al422_state_e;

  // Frame header byte offsets (payload is opaque to the writer)
  localparam int unsigned HDR_CFG_OFS      = 0;
  localparam int unsigned HDR_ACT_LO_OFS   = 1;
  localparam int unsigned HDR_ACT_HI_OFS   = 2;
  localparam int unsigned HDR_INACT_LO_OFS = 6;
  localparam int unsigned HDR_INACT_HI_OFS = 7;
  localparam int unsigned HDR_DATA_OFS     = 8;

  // Config byte fields
  localparam logic [7:0] CFG_OE_INV_MASK = 8'h20;
  localparam logic [7:0] CFG_ROWS_MASK   = 8'h1F;

endpackage

// File: rtl/al422_frame_writer.sv
// Write-side AL422 controller: pointer reset per frame, then FRAME_BYTES
// bytes clocked into the FIFO from a valid/ready byte stream.
module al422_frame_writer
  import al422_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = 8192,
  parameter int unsigned RST_CYCLES  = 4
) (
  input  logic       in_clk,
  input  logic       in_nrst,
  input  logic [7:0] s_data,
  input  logic       s_sof,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       al422_nwrst_out,
  output logic       al422_we_out,
  output logic [7:0] al422_data_out,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int unsigned RW = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BYTES - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  al422_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          nwrst_q, nwrst_d;
  logic          we_q, we_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          abort_c;

  // State, counters and registered AL422 / status outputs
  always_ff @(posedge in_clk) begin
    if (!in_nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      nwrst_q <= 1'b1;
      we_q    <= 1'b1;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      nwrst_q <= nwrst_d;
      we_q    <= we_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, handshake and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    we_d    = 1'b1;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    s_ready = 1'b0;
    // SOF is only an abort once at least one byte of the frame has gone in
    abort_c = s_valid & s_sof & (cnt_q != '0);

    unique case (state_q)
      ST_IDLE: begin
        // Drop non-SOF bytes to resync; leave the SOF byte for STREAM
        s_ready = s_valid & ~s_sof;
        if (s_valid && s_sof) begin
          state_d = ST_WRST;
          rcnt_d  = '0;
        end
      end
      ST_WRST: begin
        if (rcnt_q == RST_LAST) begin
          state_d = ST_STREAM;
          cnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      ST_STREAM: begin
        s_ready = ~(s_sof & (cnt_q != '0));
        if (abort_c) begin
          err_d   = 1'b1;
          state_d = ST_WRST;
          rcnt_d  = '0;
          cnt_d   = '0;
        end else if (s_valid) begin
          we_d   = 1'b0;
          data_d = s_data;
          if (cnt_q == CNT_LAST) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    nwrst_d = (state_d != ST_WRST);
    busy_d  = (state_d != ST_IDLE);
  end

  assign al422_nwrst_out = nwrst_q;
  assign al422_we_out    = we_q;
  assign al422_data_out  = data_q;
  assign frame_done      = done_q;
  assign frame_err       = err_q;
  assign busy            = busy_q;

endmodule
